scv_romloader: RTL and testbench

- Transmitter end of the ROMINIT write port on the SCV top level.
- Accepts the host file-download stream of 16-bit words, tagged with a file index.
- Serialises each word into paced byte writes on ROMINIT_SEL_BOOT/CHR/CART, ROMINIT_ADDR, ROMINIT_DATA and ROMINIT_VALID.
- Measures the cartridge image size and drives the cart ROM address-width configuration. Holds the console in reset while loading.

---
 rtl/scv_pkg.sv | 29 ++
 rtl/scv_romloader_if.sv | 29 ++
 rtl/scv_romloader_aw.sv | 32 +++
 rtl/scv_romloader.sv | 219 +++++++++++++++++++++
 tb/tb_scv_romloader.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/scv_pkg.sv
// scv_pkg: shared constants and types for the SCV ROM loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package scv_pkg;

  // Default host download indices.
  localparam logic [7:0] IDX_BOOT_DEF = 8'h00;
  localparam logic [7:0] IDX_CHR_DEF  = 8'h01;
  localparam logic [7:0] IDX_CART_DEF = 8'h02;

  // Byte window sizes of each ROM target.
  localparam logic [24:0] BOOT_WIN = 25'd4096;
  localparam logic [24:0] CHR_WIN  = 25'd1024;
  localparam logic [24:0] CART_WIN = 25'd131072;

  // Cart address-width limits and the value used before any cart is sized.
  localparam logic [4:0] AW_MIN   = 5'd12;
  localparam logic [4:0] AW_MAX   = 5'd17;
  localparam logic [4:0] AW_RESET = 5'd15;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LO     = 3'd1,
    GAP_LO = 3'd2,
    HI     = 3'd3,
    GAP_HI = 3'd4
  } ld_state_t;

endpackage

// File: rtl/scv_romloader_if.sv
// scv_romloader_if: host download stream in, ROMINIT byte-write port out.
// Latency: n/a (wires only).
// Backpressure: DL_WAIT from the loader side throttles DL_WR.
interface scv_romloader_if;
  logic        DL_ACTIVE;
  logic [7:0]  DL_INDEX;
  logic [24:0] DL_ADDR;
  logic [15:0] DL_DATA;
  logic        DL_WR;
  logic        DL_WAIT;
  logic        ROMINIT_SEL_BOOT;
  logic        ROMINIT_SEL_CHR;
  logic        ROMINIT_SEL_CART;
  logic [24:0] ROMINIT_ADDR;
  logic [7:0]  ROMINIT_DATA;
  logic        ROMINIT_VALID;

  modport master (
    output DL_ACTIVE, DL_INDEX, DL_ADDR, DL_DATA, DL_WR,
    input  DL_WAIT, ROMINIT_SEL_BOOT, ROMINIT_SEL_CHR, ROMINIT_SEL_CART,
           ROMINIT_ADDR, ROMINIT_DATA, ROMINIT_VALID
  );

  modport slave (
    input  DL_ACTIVE, DL_INDEX, DL_ADDR, DL_DATA, DL_WR,
    output DL_WAIT, ROMINIT_SEL_BOOT, ROMINIT_SEL_CHR, ROMINIT_SEL_CART,
           ROMINIT_ADDR, ROMINIT_DATA, ROMINIT_VALID
  );
endinterface

// File: rtl/scv_romloader_aw.sv
// scv_romloader_aw: cart ROM address width = ceil(log2(size)) clamped to [AW_MIN, AW_MAX].
// Latency: combinational.
// Backpressure: none.
module scv_romloader_aw
  import scv_pkg::*;
(
  input  logic [16:0] size,
  output logic [4:0]  aw
);

  // A size of 0 stands for the full 2^17 window (max address 0x1FFFF plus one wraps);
  // size-1 then becomes 0x1FFFF, so the bit width of size-1 is the answer in every case.
  logic [16:0] span;
  logic [4:0]  width;

  assign span = size - 17'd1;

  // Bit width of the highest byte address, then clamp.
  always_comb begin
    width = 5'd0;
    for (int i = 0; i < 17; i++) begin
      if (span[i]) width = 5'(i + 1);
    end
    aw = width;
    if (width < AW_MIN) begin
      aw = AW_MIN;
    end else if (width > AW_MAX) begin
      aw = AW_MAX;
    end
  end

endmodule

// File: rtl/scv_romloader.sv
// scv_romloader: serialises host download words into paced ROMINIT byte writes, sizes the cart, holds console reset.
// Latency: low byte strobes the cycle after DL_WR, high byte BYTE_GAP+1 cycles after that.
// Backpressure: DL_WAIT high for 2+2*BYTE_GAP cycles per word; DL_WR seen while busy is ignored.
module scv_romloader
  import scv_pkg::*;
#(
  parameter logic [7:0]  IDX_BOOT    = IDX_BOOT_DEF,
  parameter logic [7:0]  IDX_CHR     = IDX_CHR_DEF,
  parameter logic [7:0]  IDX_CART    = IDX_CART_DEF,
  parameter int unsigned BYTE_GAP    = 1,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic           CLK,
  input  logic           RST,
  scv_romloader_if.slave bus,
  output logic [4:0]     CFG_ROM_AW,
  output logic           CART_LOADED,
  output logic           SYS_RESET
);

  localparam logic [3:0] GAP_LOAD  = (BYTE_GAP == 0) ? 4'd0 : 4'(BYTE_GAP - 1);
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES);

  ld_state_t   state, state_nxt;
  logic        accept;
  logic [3:0]  gap_cnt;

  // Word in flight; only the high byte needs keeping, the low byte leaves on acceptance.
  logic [7:0]  lat_idx;
  logic [24:1] lat_word_addr;
  logic [7:0]  lat_hi;

  logic        sel_boot, sel_chr, sel_cart;
  logic [24:0] rom_addr;
  logic [7:0]  rom_data;
  logic        rom_valid;

  logic [24:0] byte_addr;
  logic [7:0]  byte_idx;
  logic [7:0]  byte_dat;
  logic        byte_go;
  logic        byte_ok;
  logic        cart_strobe;

  logic        dl_active_q;
  logic        dl_rise, dl_fall;
  logic [16:0] cart_max;
  logic [16:0] cart_size;
  logic        cart_seen;
  logic        fin_pend;
  logic [4:0]  aw_calc;
  logic [4:0]  cfg_aw;
  logic        cart_loaded;
  logic [7:0]  hold_cnt;
  logic        busy;

  // Word addresses are always even; the host's bit 0 carries no meaning.
  logic        unused_addr_lsb;
  assign unused_addr_lsb = bus.DL_ADDR[0];

  function automatic logic in_window(input logic [7:0] idx, input logic [24:0] a);
    logic ok;
    ok = 1'b0;
    if (idx == IDX_BOOT)      ok = (a < BOOT_WIN);
    else if (idx == IDX_CHR)  ok = (a < CHR_WIN);
    else if (idx == IDX_CART) ok = (a < CART_WIN);
    return ok;
  endfunction

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: one word is two byte slots, each followed by an optional gap.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.DL_WR) begin
          accept    = 1'b1;
          state_nxt = LO;
        end
      end
      LO: begin
        if (BYTE_GAP == 0) state_nxt = HI;
        else               state_nxt = GAP_LO;
      end
      GAP_LO: begin
        if (gap_cnt == 4'd0) state_nxt = HI;
      end
      HI: begin
        if (BYTE_GAP == 0) state_nxt = IDLE;
        else               state_nxt = GAP_HI;
      end
      GAP_HI: begin
        if (gap_cnt == 4'd0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Gap counter: loaded in each byte slot, counts down through the following gap.
  always_ff @(posedge CLK) begin
    if (RST)                             gap_cnt <= 4'd0;
    else if (state == LO || state == HI) gap_cnt <= GAP_LOAD;
    else if (gap_cnt != 4'd0)            gap_cnt <= gap_cnt - 4'd1;
  end

  // Pick the byte that will be strobed next cycle: the fresh low byte on accept, else the latched high byte.
  always_comb begin
    byte_addr = {lat_word_addr, 1'b1};
    byte_idx  = lat_idx;
    byte_dat  = lat_hi;
    byte_go   = (state_nxt == HI);
    if (accept) begin
      byte_addr = {bus.DL_ADDR[24:1], 1'b0};
      byte_idx  = bus.DL_INDEX;
      byte_dat  = bus.DL_DATA[7:0];
      byte_go   = 1'b1;
    end
    byte_ok = byte_go && in_window(byte_idx, byte_addr);
  end

  assign cart_strobe = byte_ok && (byte_idx == IDX_CART);

  // Word latch, target select and ROMINIT output registers; address/data hold between strobes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      lat_idx       <= 8'd0;
      lat_word_addr <= '0;
      lat_hi        <= 8'd0;
      sel_boot      <= 1'b0;
      sel_chr       <= 1'b0;
      sel_cart      <= 1'b0;
      rom_addr      <= 25'd0;
      rom_data      <= 8'd0;
      rom_valid     <= 1'b0;
    end else begin
      rom_valid <= byte_ok;
      if (byte_ok) begin
        rom_addr <= byte_addr;
        rom_data <= byte_dat;
      end
      if (accept) begin
        lat_idx       <= bus.DL_INDEX;
        lat_word_addr <= bus.DL_ADDR[24:1];
        lat_hi        <= bus.DL_DATA[15:8];
        sel_boot      <= (bus.DL_INDEX == IDX_BOOT);
        sel_chr       <= (bus.DL_INDEX == IDX_CHR);
        sel_cart      <= (bus.DL_INDEX == IDX_CART);
      end
    end
  end

  assign dl_rise   = bus.DL_ACTIVE && !dl_active_q;
  assign dl_fall   = !bus.DL_ACTIVE && dl_active_q;
  assign cart_size = cart_max + 17'd1;

  scv_romloader_aw u_aw (
    .size (cart_size),
    .aw   (aw_calc)
  );

  // Cart sizing: track the highest strobed cart byte; commit once the FSM has drained after DL_ACTIVE falls.
  always_ff @(posedge CLK) begin
    if (RST) begin
      dl_active_q <= 1'b0;
      cart_max    <= 17'd0;
      cart_seen   <= 1'b0;
      fin_pend    <= 1'b0;
      cfg_aw      <= AW_RESET;
      cart_loaded <= 1'b0;
    end else begin
      dl_active_q <= bus.DL_ACTIVE;
      if (dl_rise) begin
        cart_max  <= 17'd0;
        cart_seen <= 1'b0;
        fin_pend  <= 1'b0;
      end
      if (cart_strobe) begin
        cart_seen <= 1'b1;
        if (dl_rise || byte_addr[16:0] > cart_max) cart_max <= byte_addr[16:0];
      end
      if (dl_fall) begin
        fin_pend <= 1'b1;
      end else if (fin_pend && state == IDLE) begin
        fin_pend <= 1'b0;
        if (lat_idx == IDX_CART && cart_seen) begin
          cfg_aw      <= aw_calc;
          cart_loaded <= 1'b1;
        end
      end
    end
  end

  assign busy = bus.DL_ACTIVE || (state != IDLE);

  // Reset hold: reloads while busy, then counts out HOLD_CYCLES idle cycles.
  always_ff @(posedge CLK) begin
    if (RST)                   hold_cnt <= HOLD_LOAD;
    else if (busy)             hold_cnt <= HOLD_LOAD;
    else if (hold_cnt != 8'd0) hold_cnt <= hold_cnt - 8'd1;
  end

  assign SYS_RESET            = busy || (hold_cnt != 8'd0);
  assign CFG_ROM_AW           = cfg_aw;
  assign CART_LOADED          = cart_loaded;
  assign bus.DL_WAIT          = (state != IDLE);
  assign bus.ROMINIT_SEL_BOOT = sel_boot;
  assign bus.ROMINIT_SEL_CHR  = sel_chr;
  assign bus.ROMINIT_SEL_CART = sel_cart;
  assign bus.ROMINIT_ADDR     = rom_addr;
  assign bus.ROMINIT_DATA     = rom_data;
  assign bus.ROMINIT_VALID    = rom_valid;

endmodule

// File: tb/tb_scv_romloader.sv
// tb_scv_romloader: directed table-driven bench for the ROMINIT loader.
// Latency: checks low byte at N+1 and high byte at N+2+GAP after DL_WR at N.
// Backpressure: checks DL_WAIT window and that DL_WR during DL_WAIT is ignored.
module tb_scv_romloader;
  import scv_pkg::*;

  localparam int GAP  = 1;
  localparam int HOLD = 16;
  localparam int WIN  = 8;
  localparam int HI_K = 2 + GAP;

  logic       CLK = 1'b0;
  logic       RST;
  logic [4:0] cfg_rom_aw;
  logic       cart_loaded;
  logic       sys_reset;

  scv_romloader_if bus();

  scv_romloader #(
    .IDX_BOOT(8'h00), .IDX_CHR(8'h01), .IDX_CART(8'h02),
    .BYTE_GAP(GAP), .HOLD_CYCLES(HOLD)
  ) dut (
    .CLK(CLK), .RST(RST), .bus(bus),
    .CFG_ROM_AW(cfg_rom_aw), .CART_LOADED(cart_loaded), .SYS_RESET(sys_reset)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        valid;
    logic        wt;
    logic [2:0]  sel;
    logic [24:0] addr;
    logic [7:0]  data;
  } obs_t;

  typedef struct {
    logic [7:0]  idx;
    logic [24:0] addr;
    logic [15:0] data;
    logic [2:0]  sel;
    logic        v_lo;
    logic [24:0] a_lo;
    logic [7:0]  d_lo;
    logic        v_hi;
    logic [24:0] a_hi;
    logic [7:0]  d_hi;
  } vec_t;

  obs_t obs [WIN+1];
  vec_t vecs [8];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.valid = bus.ROMINIT_VALID;
    o.wt    = bus.DL_WAIT;
    o.sel   = {bus.ROMINIT_SEL_CART, bus.ROMINIT_SEL_CHR, bus.ROMINIT_SEL_BOOT};
    o.addr  = bus.ROMINIT_ADDR;
    o.data  = bus.ROMINIT_DATA;
    return o;
  endfunction

  // Pulse DL_WR for one word and record WIN cycles; spam re-pulses DL_WR with a different word while busy.
  task automatic run_word(input logic [7:0] idx, input logic [24:0] addr, input logic [15:0] data, input bit spam);
    bus.DL_INDEX = idx;
    bus.DL_ADDR  = addr;
    bus.DL_DATA  = data;
    bus.DL_WR    = 1'b1;
    tick();
    bus.DL_WR = 1'b0;
    obs[1] = sample();
    for (int k = 2; k <= WIN; k++) begin
      if (spam && k <= 5) begin
        bus.DL_WR   = 1'b1;
        bus.DL_ADDR = addr ^ 25'h200;
        bus.DL_DATA = ~data;
      end else begin
        bus.DL_WR   = 1'b0;
        bus.DL_ADDR = addr;
        bus.DL_DATA = data;
      end
      tick();
      obs[k] = sample();
    end
    bus.DL_WR = 1'b0;
  endtask

  // Count SYS_RESET-high cycles starting with the current one.
  task automatic count_hold(output int hi);
    hi = sys_reset ? 1 : 0;
    for (int k = 0; k < HOLD + 8; k++) begin
      tick();
      if (sys_reset) hi++;
    end
  endtask

  task automatic cart_load(input logic [24:0] a0, input logic [24:0] a1,
                           input logic [4:0] exp_aw, input logic exp_ld, input string nm);
    int hi;
    bus.DL_INDEX  = 8'h02;
    bus.DL_ACTIVE = 1'b1;
    tick();
    run_word(8'h02, a0, 16'h1234, 1'b0);
    run_word(8'h02, a1, 16'h5678, 1'b0);
    bus.DL_ACTIVE = 1'b0;
    #1;
    count_hold(hi);
    chk({nm, " aw"}, 32'(cfg_rom_aw), 32'(exp_aw));
    chk({nm, " loaded"}, 32'(cart_loaded), 32'(exp_ld));
    chk({nm, " hold"}, 32'(hi), 32'(HOLD));
  endtask

  initial begin
    int hi;
    int nv;

    vecs[0] = '{8'h00, 25'h00010, 16'hA55A, 3'b001, 1'b1, 25'h00010, 8'h5A, 1'b1, 25'h00011, 8'hA5};
    vecs[1] = '{8'h01, 25'h003FE, 16'h1234, 3'b010, 1'b1, 25'h003FE, 8'h34, 1'b1, 25'h003FF, 8'h12};
    vecs[2] = '{8'h01, 25'h00400, 16'hBEEF, 3'b010, 1'b0, 25'h003FF, 8'h12, 1'b0, 25'h003FF, 8'h12};
    vecs[3] = '{8'h00, 25'h00FFF, 16'h7788, 3'b001, 1'b1, 25'h00FFE, 8'h88, 1'b1, 25'h00FFF, 8'h77};
    vecs[4] = '{8'h00, 25'h01000, 16'h1111, 3'b001, 1'b0, 25'h00FFF, 8'h77, 1'b0, 25'h00FFF, 8'h77};
    vecs[5] = '{8'h07, 25'h00020, 16'h2222, 3'b000, 1'b0, 25'h00FFF, 8'h77, 1'b0, 25'h00FFF, 8'h77};
    vecs[6] = '{8'h02, 25'h00100, 16'hC0DE, 3'b100, 1'b1, 25'h00100, 8'hDE, 1'b1, 25'h00101, 8'hC0};
    vecs[7] = '{8'h02, 25'h20000, 16'h3333, 3'b100, 1'b0, 25'h00101, 8'hC0, 1'b0, 25'h00101, 8'hC0};

    // Reset, then idle: SYS_RESET holds 16 cycles, nothing strobes.
    RST = 1'b1;
    bus.DL_ACTIVE = 1'b0;
    bus.DL_INDEX  = 8'h00;
    bus.DL_ADDR   = 25'd0;
    bus.DL_DATA   = 16'd0;
    bus.DL_WR     = 1'b0;
    tick();
    tick();
    RST = 1'b0;
    chk("rst wait", 32'(bus.DL_WAIT), 32'd0);
    chk("rst sel", 32'(sample().sel), 32'd0);
    chk("rst addr", 32'(bus.ROMINIT_ADDR), 32'd0);
    chk("rst data", 32'(bus.ROMINIT_DATA), 32'd0);
    chk("rst aw", 32'(cfg_rom_aw), 32'd15);
    chk("rst loaded", 32'(cart_loaded), 32'd0);
    chk("rst sysreset", 32'(sys_reset), 32'd1);
    hi = sys_reset ? 1 : 0;
    nv = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (sys_reset) hi++;
      if (bus.ROMINIT_VALID) nv++;
    end
    chk("idle hold", 32'(hi), 32'(HOLD));
    chk("idle sysreset", 32'(sys_reset), 32'd0);
    chk("idle valid", 32'(nv), 32'd0);

    // Table of single words.
    for (int i = 0; i < 8; i++) begin
      run_word(vecs[i].idx, vecs[i].addr, vecs[i].data, 1'b0);
      chk($sformatf("vec%0d sel", i), 32'(obs[1].sel), 32'(vecs[i].sel));
      chk($sformatf("vec%0d lo addr", i), 32'(obs[1].addr), 32'(vecs[i].a_lo));
      chk($sformatf("vec%0d lo data", i), 32'(obs[1].data), 32'(vecs[i].d_lo));
      chk($sformatf("vec%0d hi addr", i), 32'(obs[HI_K].addr), 32'(vecs[i].a_hi));
      chk($sformatf("vec%0d hi data", i), 32'(obs[HI_K].data), 32'(vecs[i].d_hi));
      for (int k = 1; k <= WIN; k++) begin
        chk($sformatf("vec%0d valid@%0d", i, k), 32'(obs[k].valid),
            32'((k == 1) ? vecs[i].v_lo : (k == HI_K) ? vecs[i].v_hi : 1'b0));
        chk($sformatf("vec%0d wait@%0d", i, k), 32'(obs[k].wt), 32'((k <= 2 + 2 * GAP) ? 1 : 0));
      end
    end

    // DL_WR while busy is ignored; exactly two bytes of the first word go out.
    run_word(8'h01, 25'h00000, 16'hABCD, 1'b1);
    nv = 0;
    for (int k = 1; k <= WIN; k++) if (obs[k].valid) nv++;
    chk("spam bytes", 32'(nv), 32'd2);
    chk("spam lo addr", 32'(obs[1].addr), 32'h0);
    chk("spam lo data", 32'(obs[1].data), 32'hCD);
    chk("spam hi valid", 32'(obs[HI_K].valid), 32'd1);
    chk("spam hi addr", 32'(obs[HI_K].addr), 32'h1);
    chk("spam hi data", 32'(obs[HI_K].data), 32'hAB);
    chk("spam end addr", 32'(obs[WIN].addr), 32'h1);

    // Cart sizing: 0x3000 -> 14, 0x800 -> clamp 12, 0x20000 -> 17, empty -> unchanged.
    cart_load(25'h00000, 25'h02FFE, 5'd14, 1'b1, "cart3000");
    cart_load(25'h00000, 25'h007FE, 5'd12, 1'b1, "cart800");
    cart_load(25'h00000, 25'h1FFFE, 5'd17, 1'b1, "cart20000");
    cart_load(25'h20000, 25'h30000, 5'd17, 1'b1, "cartempty");

    // DL_ACTIVE falls in the same cycle as DL_WR: word still emitted, size taken after it.
    bus.DL_INDEX  = 8'h02;
    bus.DL_ACTIVE = 1'b1;
    tick();
    run_word(8'h02, 25'h00000, 16'h0102, 1'b0);
    bus.DL_ACTIVE = 1'b0;
    run_word(8'h02, 25'h03FFE, 16'hBEEF, 1'b0);
    chk("simul lo valid", 32'(obs[1].valid), 32'd1);
    chk("simul lo addr", 32'(obs[1].addr), 32'h3FFE);
    chk("simul hi valid", 32'(obs[HI_K].valid), 32'd1);
    chk("simul hi data", 32'(obs[HI_K].data), 32'hBE);
    tick();
    chk("simul aw", 32'(cfg_rom_aw), 32'd14);

    // DL_ACTIVE rising mid-hold reloads the counter.
    bus.DL_ACTIVE = 1'b1;
    tick();
    bus.DL_ACTIVE = 1'b0;
    #1;
    count_hold(hi);
    chk("midhold reload", 32'(hi), 32'(HOLD));
    chk("midhold aw kept", 32'(cfg_rom_aw), 32'd14);

    // DL_ACTIVE rising after the hold expired reasserts SYS_RESET at once.
    chk("pre reassert", 32'(sys_reset), 32'd0);
    bus.DL_ACTIVE = 1'b1;
    #1;
    chk("reassert", 32'(sys_reset), 32'd1);
    tick();
    bus.DL_ACTIVE = 1'b0;
    count_hold(hi);

    // RST between low and high byte strobes aborts the word.
    bus.DL_INDEX = 8'h00;
    bus.DL_ADDR  = 25'h40;
    bus.DL_DATA  = 16'h9988;
    bus.DL_WR    = 1'b1;
    tick();
    bus.DL_WR = 1'b0;
    chk("abort lo valid", 32'(bus.ROMINIT_VALID), 32'd1);
    chk("abort lo data", 32'(bus.ROMINIT_DATA), 32'h88);
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("abort valid", 32'(bus.ROMINIT_VALID), 32'd0);
    chk("abort addr", 32'(bus.ROMINIT_ADDR), 32'd0);
    chk("abort data", 32'(bus.ROMINIT_DATA), 32'd0);
    chk("abort sel", 32'(sample().sel), 32'd0);
    chk("abort wait", 32'(bus.DL_WAIT), 32'd0);
    chk("abort aw", 32'(cfg_rom_aw), 32'd15);
    chk("abort loaded", 32'(cart_loaded), 32'd0);
    chk("abort sysreset", 32'(sys_reset), 32'd1);
    nv = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus.ROMINIT_VALID) nv++;
    end
    chk("abort no hi", 32'(nv), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
